// File: rtl/timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | timer_pkg                                                          |
// | Register map, field positions and CTRL layout for timer_core.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package timer_pkg;

   localparam int unsigned c_num_regs = 4;

   localparam logic [1:0] c_reg_ctrl   = 2'd0;
   localparam logic [1:0] c_reg_load   = 2'd1;
   localparam logic [1:0] c_reg_count  = 2'd2;
   localparam logic [1:0] c_reg_status = 2'd3;

   localparam int unsigned c_ctrl_en_bit       = 0;
   localparam int unsigned c_ctrl_auto_bit     = 1;
   localparam int unsigned c_ctrl_ie_bit       = 2;
   localparam int unsigned c_ctrl_prescale_lsb = 8;
   localparam int unsigned c_prescale_field_w  = 24;

   localparam int unsigned c_status_exp_bit = 0;
   localparam int unsigned c_status_run_bit = 1;

   // Widest legal PRESCALE field; narrower instances zero-extend into it.
   typedef struct packed {
      logic [c_prescale_field_w-1:0] prescale;
      logic [4:0]                    rsvd;
      logic                          ie;
      logic                          auto_reload;
      logic                          en;
   } ctrl_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | timer_prescaler                                                    |
// | Counts 0..prescale while enabled and flags a tick on the last step.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module timer_prescaler #(
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      clear,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tick
);

   logic [PRESCALE_WIDTH-1:0] r_cnt;

   // >= rather than == so a PRESCALE lowered mid-run below the current
   // count wraps immediately instead of running through the full range.
   assign tick = enable && !clear && (r_cnt >= prescale);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clear || !enable || tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/timer_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | timer_core                                                         |
// | Down-counting timer with prescaler, auto-reload and level IRQ.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module timer_core #(
   parameter int REGS           = 4,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REGS-1:0]       write_en,
   input  logic [REGS-1:0]       read_en,
   input  logic [31:0]           data_in,
   output logic [REGS-1:0][31:0] data_out,
   output logic                  irq_out
);
   import timer_pkg::*;

   logic                      r_en;
   logic                      r_auto;
   logic                      r_ie;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic [31:0]               r_load;
   logic [31:0]               r_count;
   logic                      r_exp;

   logic  w_ctrl_wr;
   logic  w_start;
   logic  w_stop;
   logic  w_tick;
   logic  w_expire;
   logic  w_unused_bits;
   ctrl_t w_ctrl_rd;
   logic [31:0] w_status_rd;

   assign w_ctrl_wr = write_en[c_reg_ctrl];
   assign w_start   = w_ctrl_wr && data_in[c_ctrl_en_bit] && !r_en;
   assign w_stop    = w_ctrl_wr && !data_in[c_ctrl_en_bit];
   assign w_expire  = w_tick && (r_count <= 32'd1);

   // Reads are side-effect free and COUNT is read-only.
   assign w_unused_bits = ^{read_en, write_en[c_reg_count]};

   timer_prescaler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .enable   (r_en),
      .clear    (w_start),
      .prescale (r_prescale),
      .tick     (w_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en       <= 1'b0;
         r_auto     <= 1'b0;
         r_ie       <= 1'b0;
         r_prescale <= '0;
         r_load     <= '0;
         r_count    <= '0;
         r_exp      <= 1'b0;
      end else begin
         // A CTRL write overrides the one-shot self-stop in the same cycle.
         if (w_ctrl_wr) begin
            r_en       <= data_in[c_ctrl_en_bit];
            r_auto     <= data_in[c_ctrl_auto_bit];
            r_ie       <= data_in[c_ctrl_ie_bit];
            r_prescale <= data_in[c_ctrl_prescale_lsb +: PRESCALE_WIDTH];
         end else if (w_expire && !r_auto) begin
            r_en <= 1'b0;
         end

         if (write_en[c_reg_load]) begin
            r_load <= data_in;
         end

         if (w_start) begin
            r_count <= r_load;
         end else if (w_tick && !w_stop) begin
            if (!w_expire) begin
               r_count <= r_count - 32'd1;
            end else if (r_auto) begin
               r_count <= r_load;
            end else begin
               r_count <= '0;
            end
         end

         // Expiry takes priority over a simultaneous write-1-to-clear.
         if (w_expire) begin
            r_exp <= 1'b1;
         end else if (write_en[c_reg_status] && data_in[c_status_exp_bit]) begin
            r_exp <= 1'b0;
         end
      end
   end

   always_comb begin
      w_ctrl_rd             = '0;
      w_ctrl_rd.en          = r_en;
      w_ctrl_rd.auto_reload = r_auto;
      w_ctrl_rd.ie          = r_ie;
      w_ctrl_rd.prescale    = c_prescale_field_w'(r_prescale);

      w_status_rd                   = '0;
      w_status_rd[c_status_exp_bit] = r_exp;
      w_status_rd[c_status_run_bit] = r_en;

      data_out               = '0;
      data_out[c_reg_ctrl]   = w_ctrl_rd;
      data_out[c_reg_load]   = r_load;
      data_out[c_reg_count]  = r_count;
      data_out[c_reg_status] = w_status_rd;
   end

   assign irq_out = r_exp && r_ie;

endmodule : timer_core
`default_nettype wire

// File: doc/timer_core.md
TIMER_CORE -- requirements
Module: timer_core

Interface
REQ-001 SHALL have parameter REGS, default 4, meaning number of register slots exposed to the bus adapter (fixed at 4; other values are illegal).
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 8, meaning width of the CTRL prescale field and of the prescaler counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 write_en  input  REGS  one-hot per-register write strobe from the adapter.
REQ-006 read_en  input  REGS  per-register read strobe; ignored (reads have no side effects).
REQ-007 data_in  input  32  write data, valid in the cycle its write_en bit is high.
REQ-008 data_out  output  REGS x 32  array of register read values, index = register address.
REQ-009 irq_out  output  1  level interrupt to the adapter.

Function
REQ-010 Register map: 0 CTRL, 1 LOAD, 2 COUNT (read-only), 3 STATUS.
REQ-011 CTRL fields: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable), bits[8+PRESCALE_WIDTH-1:8] PRESCALE; all other bits read 0.
REQ-012 STATUS fields: bit0 EXP (expired, write-1-to-clear), bit1 RUN (read-only copy of EN); all other bits read 0.
REQ-013 data_out SHALL be combinational from the registers, so a value written in cycle N reads back from cycle N+1.
REQ-014 A LOAD write SHALL update LOAD only; the current COUNT is unaffected until the next start or reload.
REQ-015 A COUNT write SHALL be ignored.
REQ-016 A CTRL write taking EN from 0 to 1 (start) SHALL, at the next edge, set COUNT to LOAD and clear the prescaler.
REQ-017 A CTRL write with EN=1 while already running SHALL update AUTO, IE and PRESCALE without restarting.
REQ-018 Prescaler: counts 0..PRESCALE while EN=1; a tick occurs in the cycle it equals PRESCALE, after which it wraps to 0. PRESCALE=0 gives a tick every cycle.
REQ-019 Prescaler SHALL hold at 0 while EN=0.
REQ-020 On a tick with COUNT > 1: COUNT decrements by 1.
REQ-021 On a tick with COUNT <= 1: EXP is set.
REQ-021a In that same tick, if AUTO=1, COUNT reloads from LOAD.
REQ-021b In that same tick, if AUTO=0, COUNT becomes 0 and EN clears (one-shot stop).
REQ-022 LOAD=0 SHALL behave as LOAD=1: expiry on the first tick.
REQ-023 Period with AUTO=1 is max(LOAD,1) x (PRESCALE+1) cycles.
REQ-024 Simultaneous STATUS EXP-clear write and expiry: set wins, so EXP=1.
REQ-025 Simultaneous CTRL write with EN=0 and expiry: the write wins, EN=0, and COUNT holds its pre-tick value; EXP is still set.
REQ-026 irq_out = EXP AND IE, combinational, with no additional latency.
REQ-027 Only one write_en bit is assumed high per cycle; if several are high, each addressed register updates independently.

Reset
REQ-028 On reset assertion all registers SHALL clear immediately: CTRL, LOAD, COUNT and STATUS = 0, prescaler = 0.
REQ-029 While in reset, all data_out words = 0 and irq_out = 0.
REQ-030 Reset asserted mid-count SHALL abort the count; no expiry or irq follows deassertion.

Structure
REQ-031 Package timer_pkg SHALL hold register index constants, CTRL/STATUS bit positions, and a packed struct for CTRL.
REQ-032 Sub-module timer_prescaler (inputs: enable, clear, prescale; output: tick) SHALL implement REQ-018 and REQ-019.
REQ-033 No other sub-modules.

Verification
REQ-034 LOAD=3, CTRL=0x1 (EN, PRESCALE=0) -> COUNT reads 3,2,1 on consecutive cycles; then EXP=1, COUNT=0, EN=0; irq_out stays 0.
REQ-035 LOAD=2, CTRL=0x0000_0207 (EN, AUTO, IE, PRESCALE=2) -> EXP set every 6 cycles; irq_out high after the first expiry.
REQ-036 With EXP=1, write STATUS=0x1 in the exact expiry cycle of a running AUTO timer -> EXP remains 1.
REQ-037 With EXP=1 and IE=1, write STATUS=0x1 in a non-expiry cycle -> EXP=0 and irq_out=0 the next cycle.
REQ-038 Running with LOAD=100, write LOAD=5 -> COUNT continues from its current value; next reload is to 5.
REQ-039 Assert reset mid-count with LOAD=10 -> all data_out=0 immediately; after release no irq, and COUNT stays 0 until restart.
